// File: rtl/datapath_writeback.sv
// rtl/datapath_writeback.sv - writeback stage with 8x16 register file and retire counter
//
// Purpose: aligns validity with the EX/WB pipeline register, decodes the
// instruction in EX_WB to pick a destination and write value, updates the
// register file, serves two bypassed read ports and counts retirements.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   EX_WB          in   {PC, data1, data2, ALUout, instr} bundle from execute
//   ex_valid       in   valid for the bundle being registered into EX_WB
//   i_ldst_rddata  in   load data from data memory (valid during WB of ld)
//   rd_addr1/2     in   decode-stage read addresses
//   rd_data1/2     out  read data with write-through bypass
//   dataw          out  value written this cycle
//   regw           out  destination register written this cycle
//   wb_en          out  a register write happens this cycle
//   retired        out  count of valid instructions completed (wraps)

module datapath_writeback #(
  parameter int EX_WB_WIDTH = 80
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [EX_WB_WIDTH-1:0] EX_WB,
  input  logic                   ex_valid,
  input  logic [15:0]            i_ldst_rddata,
  input  logic [2:0]             rd_addr1,
  input  logic [2:0]             rd_addr2,
  output logic [15:0]            rd_data1,
  output logic [15:0]            rd_data2,
  output logic [15:0]            dataw,
  output logic [2:0]             regw,
  output logic                   wb_en,
  output logic [15:0]            retired
);

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  logic        wb_valid_q;
  logic [15:0] retired_q, retired_d;
  logic [15:0] rf_q [8];

  logic [15:0] pc_f, alu_f, instr_f;
  logic [4:0]  opcode;
  logic [2:0]  rx;
  logic        wr_alu, wr_ld, wr_call;

  assign pc_f    = EX_WB[79:64];
  assign alu_f   = EX_WB[31:16];
  assign instr_f = EX_WB[15:0];
  assign opcode  = instr_f[4:0];
  assign rx      = instr_f[7:5];

  // data1/data2 and the upper instruction byte are carried for other
  // stages; writeback has no use for them.
  logic unused_fields;
  assign unused_fields = ^{EX_WB[63:32], instr_f[15:8]};

  always_comb begin
    wr_alu  = 1'b0;
    wr_ld   = 1'b0;
    wr_call = 1'b0;
    unique case (opcode)
      OP_MV, OP_ADD, OP_SUB, OP_MVI, OP_ADDI, OP_SUBI, OP_MVHI: wr_alu = 1'b1;
      OP_LD:                                                   wr_ld = 1'b1;
      OP_CALL, OP_CALLR:                                       wr_call = 1'b1;
      default: ;
    endcase
  end

  // Calls always link into R7 regardless of the Rx field.
  always_comb begin
    wb_en = wb_valid_q & (wr_alu | wr_ld | wr_call);
    regw  = wr_call ? 3'd7 : rx;
    if (wr_call)    dataw = pc_f;
    else if (wr_ld) dataw = i_ldst_rddata;
    else            dataw = alu_f;
  end

  // Write-through bypass so decode sees the value being written this cycle.
  always_comb begin
    rd_data1 = (wb_en && rd_addr1 == regw) ? dataw : rf_q[rd_addr1];
    rd_data2 = (wb_en && rd_addr2 == regw) ? dataw : rf_q[rd_addr2];
  end

  assign retired_d = wb_valid_q ? retired_q + 16'd1 : retired_q;
  assign retired   = retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      retired_q  <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      wb_valid_q <= ex_valid;
      retired_q  <= retired_d;
      if (wb_en) rf_q[regw] <= dataw;
    end
  end

endmodule

// File: tb/tb_datapath_writeback.sv
// tb/tb_datapath_writeback.sv - directed self-checking bench for datapath_writeback

module tb_datapath_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] EX_WB;
  logic        ex_valid;
  logic [15:0] i_ldst_rddata;
  logic [2:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, dataw, retired;
  logic [2:0]  regw;
  logic        wb_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_writeback #(.EX_WB_WIDTH(80)) dut (
    .clk(clk), .reset(reset), .EX_WB(EX_WB), .ex_valid(ex_valid),
    .i_ldst_rddata(i_ldst_rddata), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .dataw(dataw), .regw(regw),
    .wb_en(wb_en), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [15:0] pc, input logic [15:0] alu,
                                     input logic [2:0] rx, input logic [4:0] op);
    return {pc, 16'hAAAA, 16'h5555, alu, 8'hC3, rx, op};
  endfunction

  // Called at a negedge; returns at the following negedge with the bundle
  // sitting in EX_WB and wb_valid equal to v.
  task automatic issue(input logic [79:0] b, input logic v, input logic [15:0] ld);
    ex_valid = v;
    @(posedge clk);
    #1;
    EX_WB         = b;
    i_ldst_rddata = ld;
    ex_valid      = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; EX_WB = '0; ex_valid = 1'b0; i_ldst_rddata = '0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd7;
    #12;
    check("rst_retired", retired, 16'h0000);
    check("rst_wb_en", wb_en, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_rd1", rd_data1, 16'h0000);
    check("rst_rd2", rd_data2, 16'h0000);

    // addi R2, ALUout 0x1234, bypass on port 1
    rd_addr1 = 3'd2; rd_addr2 = 3'd3;
    issue(mk(16'h0010, 16'h1234, 3'd2, 5'b10001), 1'b1, 16'h0000);
    check("addi_wb_en", wb_en, 1'b1);
    check("addi_regw", regw, 3'd2);
    check("addi_dataw", dataw, 16'h1234);
    check("addi_bypass", rd_data1, 16'h1234);
    check("addi_rd2", rd_data2, 16'h0000);

    // ld R5 picks memory data, not ALUout
    rd_addr2 = 3'd5;
    issue(mk(16'h0011, 16'h0042, 3'd5, 5'b00100), 1'b1, 16'hBEEF);
    check("ld_retired", retired, 16'h0001);
    check("ld_rf2", rd_data1, 16'h1234);
    check("ld_dataw", dataw, 16'hBEEF);
    check("ld_regw", regw, 3'd5);
    check("ld_bypass2", rd_data2, 16'hBEEF);

    // cmp: no write
    issue(mk(16'h0012, 16'h7777, 3'd5, 5'b00110), 1'b1, 16'h9999);
    check("cmp_wb_en", wb_en, 1'b0);
    check("cmp_retired", retired, 16'h0002);
    check("cmp_rf5", rd_data2, 16'hBEEF);
    check("cmp_rf2", rd_data1, 16'h1234);

    // callr with wb_valid=0 first, then valid
    rd_addr1 = 3'd7; rd_addr2 = 3'd3;
    issue(mk(16'h0106, 16'h3333, 3'd3, 5'b01100), 1'b0, 16'h0000);
    check("callr_inv_wb_en", wb_en, 1'b0);
    check("callr_inv_r7", rd_data1, 16'h0000);
    check("callr_inv_ret", retired, 16'h0003);
    issue(mk(16'h0106, 16'h3333, 3'd3, 5'b01100), 1'b1, 16'h0000);
    check("callr_retired", retired, 16'h0003);
    check("callr_wb_en", wb_en, 1'b1);
    check("callr_regw", regw, 3'd7);
    check("callr_dataw", dataw, 16'h0106);

    // call links R7 too, ignores Rx=3
    issue(mk(16'h0222, 16'h4444, 3'd3, 5'b11100), 1'b1, 16'h0000);
    check("call_r7_prev", dut.rf_q[7], 16'h0106);
    check("call_regw", regw, 3'd7);
    check("call_bypass", rd_data1, 16'h0222);
    check("call_r3", rd_data2, 16'h0000);
    check("call_retired", retired, 16'h0004);

    // back-to-back writes to R1, both ports bypass
    rd_addr1 = 3'd1; rd_addr2 = 3'd1;
    issue(mk(16'h0030, 16'h1111, 3'd1, 5'b00001), 1'b1, 16'h0000);
    check("b2b1_rd1", rd_data1, 16'h1111);
    issue(mk(16'h0031, 16'h2222, 3'd1, 5'b00010), 1'b1, 16'h0000);
    check("b2b2_rd1", rd_data1, 16'h2222);
    check("b2b2_rd2", rd_data2, 16'h2222);
    issue(mk(16'h0032, 16'h6666, 3'd4, 5'b11111), 1'b1, 16'h0000);
    check("undef_wb_en", wb_en, 1'b0);
    check("b2b_rf1", rd_data1, 16'h2222);
    issue(mk(16'h0033, 16'h0F0F, 3'd4, 5'b10110), 1'b1, 16'h0000);
    check("mvhi_regw", regw, 3'd4);
    check("mvhi_dataw", dataw, 16'h0F0F);
    check("mvhi_retired", retired, 16'h0008);

    // wrap: reset, then 65536 consecutive valid non-writing instructions
    reset = 1'b1; #1;
    check("rst2_r1", rd_data1, 16'h0000);
    check("rst2_retired", retired, 16'h0000);
    @(negedge clk); reset = 1'b0;
    EX_WB = mk(16'h0040, 16'h0000, 3'd0, 5'b00110);
    ex_valid = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    check("wrap_ffff", retired, 16'hFFFF);
    ex_valid = 1'b0;
    @(negedge clk);
    check("wrap_zero", retired, 16'h0000);

    // reset during a valid add R1 discards the write
    issue(mk(16'h0050, 16'h5555, 3'd1, 5'b00001), 1'b1, 16'h0000);
    check("rstmid_wb_en_pre", wb_en, 1'b1);
    reset = 1'b1; #1;
    check("rstmid_wb_en", wb_en, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rstmid_r1", rd_data1, 16'h0000);
    check("rstmid_wb_en_post", wb_en, 1'b0);
    check("rstmid_retired", retired, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
